// File: rtl/alpha_mem_pkg.sv
// Shared types for the memory interface unit: request/response packet, access
// type and size encodings, and FSM states.
package alpha_mem_pkg;

  localparam int PKT_ADDR_W = 32;
  localparam int PKT_DATA_W = 64;
  localparam int SIZE_W     = 3;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mem_type_e;

  typedef enum logic [SIZE_W-1:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2,
    QUAD = 3'd3,
    LINE = 3'd4
  } mem_size_e;

  typedef struct packed {
    logic                  vld;
    mem_type_e             typ;
    mem_size_e             size;
    logic                  last;
    logic [PKT_ADDR_W-1:0] addr;
    logic [PKT_DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } mc_state_e;

  // Channel-id width; a single channel still gets a 1-bit id.
  function automatic int ch_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alpha_rr_arb.sv
// N-way round-robin arbiter: grants the first requester at or after the
// pointer, and moves the pointer past the winner only when en is high.
module alpha_rr_arb
  import alpha_mem_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = ch_id_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_vld
);

  logic [ID_W-1:0] ptr;
  int              idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant_id   = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en && grant_vld) begin
      ptr <= ID_W'((int'(grant_id) + 1) % N);
    end
  end

endmodule

// File: rtl/alpha_miu_mc.sv
// Multi-channel memory interface unit: round-robin arbitration of CPU request
// ports onto a single bus, line bursts split into ascending beats, tagged responses.
module alpha_miu_mc
  import alpha_mem_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int LINE_BEATS = 2,
  parameter int BEAT_BYTES = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  pkt_t                    cpu_req_pkt [N_CH],
  output logic [N_CH-1:0]         cpu_req_ack,
  output pkt_t                    cpu_resp_pkt [N_CH],
  output logic                    err_line_store,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic                    bus_valid,
  output logic [8*BEAT_BYTES-1:0] bus_wdata,
  output logic [SIZE_W-1:0]       bus_wsize,
  output logic                    bus_write,
  input  logic [8*BEAT_BYTES-1:0] bus_rdata,
  input  logic                    bus_ready
);

  localparam int CH_W       = ch_id_w(N_CH);
  localparam int DW         = 8 * BEAT_BYTES;
  localparam int LINE_BYTES = LINE_BEATS * BEAT_BYTES;
  localparam int CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int OFF_W      = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;
  localparam logic [PKT_ADDR_W-1:0] LINE_MASK = ~(PKT_ADDR_W'(LINE_BYTES - 1));

  mc_state_e        state, state_nxt;
  logic [N_CH-1:0]  req_vld;
  logic [N_CH-1:0]  grant;
  logic [CH_W-1:0]  grant_id;
  logic             grant_vld;
  logic             ack_fire;
  logic             start_burst;
  pkt_t             sel_pkt;
  pkt_t             issue;
  logic [CH_W-1:0]  issue_ch;
  pkt_t             burst_pkt;
  logic [CH_W-1:0]  burst_ch;
  logic [CNT_W-1:0] beat_cnt;
  pkt_t             t2;
  logic [CH_W-1:0]  t2_ch;
  int               lane;

  for (genvar i = 0; i < N_CH; i++) begin : g_req
    assign req_vld[i] = cpu_req_pkt[i].vld;
  end

  alpha_rr_arb #(
    .N    (N_CH),
    .ID_W (CH_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_vld),
    .en        (ack_fire),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  assign sel_pkt     = cpu_req_pkt[grant_id];
  assign ack_fire    = grant_vld && bus_ready && (state == IDLE);
  assign cpu_req_ack = ack_fire ? grant : '0;
  assign start_burst = ack_fire && (sel_pkt.size == LINE) && (sel_pkt.typ != STORE)
                       && (LINE_BEATS > 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_burst) state_nxt = BURST;
      BURST:   if (bus_ready && issue.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat on the bus this cycle: the registered burst, or the granted request.
  always_comb begin
    issue    = '0;
    issue_ch = '0;
    if (state == BURST) begin
      issue      = burst_pkt;
      issue.addr = burst_pkt.addr + PKT_ADDR_W'(beat_cnt) * PKT_ADDR_W'(BEAT_BYTES);
      issue.last = (beat_cnt == CNT_W'(LINE_BEATS - 1));
      issue_ch   = burst_ch;
    end else if (grant_vld) begin
      issue      = sel_pkt;
      issue.vld  = 1'b1;
      issue.last = 1'b1;
      issue_ch   = grant_id;
      if (sel_pkt.size == LINE) begin
        issue.size = QUAD;
        if (sel_pkt.typ != STORE) begin
          issue.addr = sel_pkt.addr & LINE_MASK;
          issue.last = (LINE_BEATS == 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      burst_pkt <= '0;
      burst_ch  <= '0;
    end else if (bus_ready) begin
      if (start_burst) begin
        beat_cnt  <= CNT_W'(1);
        burst_pkt <= issue;
        burst_ch  <= issue_ch;
      end else if (state == BURST) begin
        beat_cnt <= issue.last ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_line_store <= 1'b0;
    end else if (ack_fire && (sel_pkt.size == LINE) && (sel_pkt.typ == STORE)) begin
      err_line_store <= 1'b1;
    end
  end

  always_comb begin
    lane      = (BEAT_BYTES > 1) ? int'(issue.addr[OFF_W-1:0]) : 0;
    bus_valid = issue.vld;
    bus_addr  = ADDR_W'(issue.addr);
    bus_wsize = issue.size;
    bus_write = issue.vld && (issue.typ == STORE);
    bus_wdata = DW'(issue.data) << (8 * lane);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t2    <= '0;
      t2_ch <= '0;
    end else if (bus_ready) begin
      t2    <= issue;
      t2_ch <= issue_ch;
    end
  end

  // Read data arrives one cycle after the beat, so it pairs with t2.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cpu_resp_pkt[i]      = t2;
      cpu_resp_pkt[i].vld  = t2.vld && bus_ready && (t2_ch == CH_W'(i));
      cpu_resp_pkt[i].data = (t2.vld && (t2.typ != STORE)) ? PKT_DATA_W'(bus_rdata) : '0;
    end
  end

endmodule

// File: tb/tb_alpha_miu_mc.sv
// Self-checking bench for alpha_miu_mc: directed requests, a memory responder,
// and a scoreboard of expected bus beats and tagged responses.
`timescale 1ns/1ps
module tb_alpha_miu_mc;
  import alpha_mem_pkg::*;

  localparam int N_CH       = 2;
  localparam int LINE_BEATS = 2;
  localparam int BEAT_BYTES = 8;
  localparam int ADDR_W     = 32;
  localparam int EW         = 1 + 2 + 3 + 1 + 32 + 64;
  localparam int BW         = 32 + 1 + 3 + 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rdy = 1'b1;
  pkt_t              req [N_CH];
  logic [N_CH-1:0]   ack;
  pkt_t              resp [N_CH];
  logic              err;
  logic [31:0]       bus_addr;
  logic              bus_valid;
  logic [63:0]       bus_wdata;
  logic [2:0]        bus_wsize;
  logic              bus_write;
  logic [63:0]       bus_rdata;
  logic [31:0]       rd_addr;

  logic [EW-1:0]     exp_q[$];
  logic [BW-1:0]     bus_q[$];
  int                ack_ch_log[$];
  int                ack_cyc_log[$];
  int                resp_cyc_log[$];
  int                total = 0;
  int                bad = 0;
  int                cycle = 0;

  always #5 clk = ~clk;

  alpha_miu_mc #(
    .N_CH       (N_CH),
    .LINE_BEATS (LINE_BEATS),
    .BEAT_BYTES (BEAT_BYTES),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_pkt    (req),
    .cpu_req_ack    (ack),
    .cpu_resp_pkt   (resp),
    .err_line_store (err),
    .bus_addr       (bus_addr),
    .bus_valid      (bus_valid),
    .bus_wdata      (bus_wdata),
    .bus_wsize      (bus_wsize),
    .bus_write      (bus_write),
    .bus_rdata      (bus_rdata),
    .bus_ready      (rdy)
  );

  function automatic logic [63:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 64'hDEADBEEF_CAFEF00D : {a ^ 32'h5A5A_0000, ~a};
  endfunction

  // Memory responder: read data for the beat accepted in the previous cycle.
  assign bus_rdata = mem_f(rd_addr);
  always @(posedge clk) begin
    if (reset) rd_addr <= '0;
    else if (bus_valid && rdy) rd_addr <= bus_addr;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int ch, input pkt_t p);
    logic [31:0] a;
    logic [31:0] base;
    logic [63:0] wd;
    mem_size_e   sz;
    if (p.size == LINE && p.typ != STORE) begin
      base = p.addr & ~32'(LINE_BEATS * BEAT_BYTES - 1);
      for (int k = 0; k < LINE_BEATS; k++) begin
        a = base + 32'(k * BEAT_BYTES);
        bus_q.push_back({a, 1'b0, QUAD, p.data});
        exp_q.push_back({1'(ch), p.typ, QUAD, 1'(k == LINE_BEATS - 1), a, mem_f(a)});
      end
    end else begin
      sz = (p.size == LINE) ? QUAD : p.size;
      wd = p.data << (8 * (p.addr % 8));
      bus_q.push_back({p.addr, 1'(p.typ == STORE), sz, wd});
      exp_q.push_back({1'(ch), p.typ, sz, 1'b1, p.addr,
                       (p.typ == STORE) ? 64'h0 : mem_f(p.addr)});
    end
  endtask

  // Monitor: acks push expectations; bus beats and responses pop and compare.
  always @(negedge clk) begin
    cycle++;
    if (!reset) begin
      if (!rdy) begin
        chk("stall_ack", ack, '0);
        for (int ch = 0; ch < N_CH; ch++) chk("stall_resp_vld", resp[ch].vld, 1'b0);
      end else begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (ack[ch]) begin
            ack_ch_log.push_back(ch);
            ack_cyc_log.push_back(cycle);
            push_exp(ch, req[ch]);
          end
        end
        if (bus_valid) begin
          if (bus_q.size() == 0) chk("bus_unexpected", bus_valid, 1'b0);
          else chk("bus_beat", {bus_addr, bus_write, bus_wsize, bus_wdata}, bus_q.pop_front());
        end
        for (int ch = 0; ch < N_CH; ch++) begin
          if (resp[ch].vld) begin
            resp_cyc_log.push_back(cycle);
            if (exp_q.size() == 0) chk("resp_unexpected", resp[ch].vld, 1'b0);
            else chk("resp", {1'(ch), resp[ch].typ, resp[ch].size, resp[ch].last,
                              resp[ch].addr, resp[ch].data}, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int ch, input mem_type_e t, input mem_size_e s,
                      input logic [31:0] a, input logic [63:0] d);
    int n;
    n = 0;
    req[ch] = '{vld: 1'b1, typ: t, size: s, last: 1'b0, addr: a, data: d};
    do begin
      @(negedge clk);
      n++;
    end while (!ack[ch] && n < 100);
    if (!ack[ch]) chk("ack_timeout", ack[ch], 1'b1);
    @(posedge clk);
    #1;
    req[ch] = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size() + bus_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    ack_ch_log.delete();
    ack_cyc_log.delete();
    resp_cyc_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    req[0] = '0;
    req[1] = '0;
    do_reset();

    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 64'h0);
    chk("rst_bus_wsize", bus_wsize, 3'h0);
    chk("rst_bus_write", bus_write, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ack", ack, 2'b00);
    chk("rst_resp0", {resp[0].vld, resp[0].data}, 65'h0);
    chk("rst_resp1", {resp[1].vld, resp[1].data}, 65'h0);
    chk("rst_state", dut.state, IDLE);

    // Single LOAD quad with a fixed read pattern.
    clear_logs();
    send(0, LOAD, QUAD, 32'h100, 64'h0);
    drain();
    chk("load_resp_lat", resp_cyc_log[0] - ack_cyc_log[0], 1);

    // Line FETCH split into two ascending beats, one ack.
    clear_logs();
    send(1, FETCH, LINE, 32'h1238, 64'h1111);
    drain();
    chk("line_acks", ack_ch_log.size(), 1);
    chk("line_resp0_lat", resp_cyc_log[0] - ack_cyc_log[0], 1);
    chk("line_resp1_lat", resp_cyc_log[1] - ack_cyc_log[0], 2);

    // Byte STORE shifted to lane 3.
    send(0, STORE, BYTE, 32'h203, 64'hAB);
    drain();

    // Both channels requesting back to back from a fresh pointer.
    do_reset();
    clear_logs();
    fork
      begin
        send(0, LOAD, QUAD, 32'h300, 64'h0);
        send(0, LOAD, WORD, 32'h314, 64'h0);
        send(0, LOAD, HALF, 32'h322, 64'h0);
      end
      begin
        send(1, LOAD, QUAD, 32'h400, 64'h0);
        send(1, FETCH, LINE, 32'h500, 64'h0);
        send(1, LOAD, BYTE, 32'h611, 64'h0);
      end
    join
    drain();
    chk("rr_ack_count", ack_ch_log.size(), 6);
    if (ack_ch_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("rr_ack_ch", ack_ch_log[i], i % 2);
      chk("rr_gap01", ack_cyc_log[1] - ack_cyc_log[0], 1);
      chk("rr_gap23", ack_cyc_log[3] - ack_cyc_log[2], 1);
      chk("rr_burst_gap", ack_cyc_log[4] - ack_cyc_log[3], 2);
      chk("rr_gap45", ack_cyc_log[5] - ack_cyc_log[4], 1);
    end

    // Three stall cycles with beat 1 of a burst on the bus.
    send(0, FETCH, LINE, 32'h2000, 64'h0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", bus_addr, 32'h2008);
      chk("stall_valid", bus_valid, 1'b1);
      chk("stall_cnt", dut.beat_cnt, 1);
    end
    @(posedge clk);
    #1;
    rdy = 1'b1;
    drain();

    // Line-sized STORE: single QUAD beat and sticky error.
    chk("err_pre", err, 1'b0);
    send(1, STORE, LINE, 32'h408, 64'h0123_4567_89AB_CDEF);
    drain();
    chk("err_set", err, 1'b1);
    send(0, LOAD, QUAD, 32'h700, 64'h0);
    drain();
    chk("err_sticky", err, 1'b1);

    // Reset while beat 1 of a burst is on the bus.
    send(1, FETCH, LINE, 32'h3000, 64'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_valid", bus_valid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_state", dut.state, IDLE);
    exp_q.delete();
    bus_q.delete();
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    clear_logs();
    send(0, LOAD, QUAD, 32'h100, 64'h0);
    drain();
    chk("post_rst_resp", resp_cyc_log.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
